// File: rtl/jk_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_writer
// Purpose  : Write-side driver for a W-bit register bank built from JK flops.
//            Accepts plain target words over valid/ready and converts each one
//            into per-bit J/K excitation. It then reads the bank back,
//            re-drives on mismatch and reports persistent failures.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            in_valid/in_data/in_ready - target word handshake
//            jk_j/jk_k      - J and K inputs of the bank
//            jk_strobe      - bank clock enable (bank updates at end of cycle)
//            q_fb           - bank Q readback
//            done/err       - one-cycle completion / abandonment pulses
//            err_count      - saturating count of err pulses
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_writer #(
  parameter int W          = 8,
  parameter int USE_TOGGLE = 0,
  parameter int FB_LAT     = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic [W-1:0] jk_j,
  output logic [W-1:0] jk_k,
  output logic         jk_strobe,
  input  logic [W-1:0] q_fb,
  output logic         done,
  output logic         err,
  output logic [7:0]   err_count
);

  localparam logic [2:0] WAIT_LAST = 3'(FB_LAT - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t       state_q;
  logic [W-1:0] shadow_q;
  logic [W-1:0] target_q;
  logic [2:0]   retry_q;
  logic [2:0]   wait_q;
  logic         in_ready_q;
  logic [W-1:0] jk_j_q;
  logic [W-1:0] jk_k_q;
  logic         jk_strobe_q;
  logic         done_q;
  logic         err_q;
  logic [7:0]   err_count_q;

  // Excitation for the next DRIVE cycle. From IDLE the bank is believed to
  // hold shadow_q and the goal is in_data; from CHECK (retry) the readback
  // just sampled is the freshest belief, so it replaces shadow_q directly.
  logic [W-1:0] exc_cur_d;
  logic [W-1:0] exc_tgt_d;
  logic [W-1:0] exc_diff_d;
  logic [W-1:0] exc_j_d;
  logic [W-1:0] exc_k_d;

  always_comb begin
    exc_cur_d  = shadow_q;
    exc_tgt_d  = in_data;
    if (state_q == S_CHECK) begin
      exc_cur_d = q_fb;
      exc_tgt_d = target_q;
    end
    exc_diff_d = exc_cur_d ^ exc_tgt_d;
    if (USE_TOGGLE != 0) begin
      exc_j_d = exc_diff_d;
      exc_k_d = exc_diff_d;
    end else begin
      exc_j_d = exc_diff_d & exc_tgt_d;
      exc_k_d = exc_diff_d & ~exc_tgt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      target_q    <= '0;
      retry_q     <= '0;
      wait_q      <= '0;
      in_ready_q  <= 1'b1;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      jk_strobe_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      // Pulses and bank drive are one-cycle by default.
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      jk_j_q      <= '0;
      jk_k_q      <= '0;
      jk_strobe_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            target_q <= in_data;
            retry_q  <= '0;
            if (in_data == shadow_q) begin
              // Bank already holds the word: complete without a strobe.
              done_q <= 1'b1;
            end else begin
              state_q     <= S_DRIVE;
              in_ready_q  <= 1'b0;
              jk_j_q      <= exc_j_d;
              jk_k_q      <= exc_k_d;
              jk_strobe_q <= 1'b1;
            end
          end
        end

        S_DRIVE: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= S_CHECK;
          end else begin
            wait_q <= wait_q + 3'd1;
          end
        end

        S_CHECK: begin
          shadow_q <= q_fb;
          if (q_fb == target_q) begin
            done_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
          end else if (retry_q < RETRY_MAX) begin
            retry_q     <= retry_q + 3'd1;
            jk_j_q      <= exc_j_d;
            jk_k_q      <= exc_k_d;
            jk_strobe_q <= 1'b1;
            state_q     <= S_DRIVE;
          end else begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_IDLE;
            if (err_count_q != 8'hFF) begin
              err_count_q <= err_count_q + 8'd1;
            end
          end
        end

        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign jk_j      = jk_j_q;
  assign jk_k      = jk_k_q;
  assign jk_strobe = jk_strobe_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_writer
// Purpose  : Self-checking bench for jk_bank_writer (W=4). One instance in
//            set/reset mode with a behavioural JK bank whose readback can be
//            corrupted or stuck, one instance in toggle mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_bank_writer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- set/reset-mode instance ----------------
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] jk_j, jk_k;
  logic         jk_strobe;
  logic [W-1:0] q_fb;
  logic         done, err;
  logic [7:0]   err_count;
  logic [W-1:0] bank0, xor_mask, stuck0;

  jk_bank_writer #(.W(W), .USE_TOGGLE(0), .FB_LAT(1), .MAX_RETRY(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .jk_j(jk_j), .jk_k(jk_k), .jk_strobe(jk_strobe),
    .q_fb(q_fb), .done(done), .err(err), .err_count(err_count)
  );

  // ---------------- toggle-mode instance ----------------
  logic         t_in_valid;
  logic [W-1:0] t_in_data;
  logic         t_in_ready;
  logic [W-1:0] t_j, t_k;
  logic         t_strobe;
  logic [W-1:0] t_qfb;
  logic         t_done, t_err;
  logic [7:0]   t_errc;
  logic [W-1:0] bank1;

  jk_bank_writer #(.W(W), .USE_TOGGLE(1), .FB_LAT(1), .MAX_RETRY(2)) u_tog (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_data(t_in_data),
    .in_ready(t_in_ready), .jk_j(t_j), .jk_k(t_k), .jk_strobe(t_strobe),
    .q_fb(t_qfb), .done(t_done), .err(t_err), .err_count(t_errc)
  );

  // Behavioural JK bank.
  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      if (jk_strobe) bank0 <= jk_next(bank0, jk_j, jk_k);
      if (t_strobe)  bank1 <= jk_next(bank1, t_j, t_k);
    end
  end

  assign q_fb  = (bank0 ^ xor_mask) & ~stuck0;
  assign t_qfb = bank1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic is_err;
    int   at_cyc;
  } exp_t;
  exp_t sbq[$];

  // Scoreboard: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (done || err)) begin
      chk("pulse_excl", {30'd0, done & err, jk_strobe}, 32'd0);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_kind", {31'd0, err}, {31'd0, e.is_err});
        chk("pulse_cycle", cyc, e.at_cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic write_word(input logic [W-1:0] d, input logic [W-1:0] ej,
                            input logic [W-1:0] ek, input logic es, input int lat);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    sbq.push_back('{is_err: 1'b0, at_cyc: cyc + lat});
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    chk("strobe", {31'd0, jk_strobe}, {31'd0, es});
    chk("jk_j", {28'd0, jk_j}, {28'd0, ej});
    chk("jk_k", {28'd0, jk_k}, {28'd0, ek});
    if (es) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    drain();
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
    logic         es;
    int           lat;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int nstrobe;
    // Bank starts at 0000; each row builds on the previous row's contents.
    tbl[0] = '{d: 4'b1010, ej: 4'b1010, ek: 4'b0000, es: 1'b1, lat: 4};
    tbl[1] = '{d: 4'b1010, ej: 4'b0000, ek: 4'b0000, es: 1'b0, lat: 1};
    tbl[2] = '{d: 4'b0110, ej: 4'b0100, ek: 4'b1000, es: 1'b1, lat: 4};
    tbl[3] = '{d: 4'b1111, ej: 4'b1001, ek: 4'b0000, es: 1'b1, lat: 4};
    tbl[4] = '{d: 4'b0000, ej: 4'b0000, ek: 4'b1111, es: 1'b1, lat: 4};
    tbl[5] = '{d: 4'b0000, ej: 4'b0000, ek: 4'b0000, es: 1'b0, lat: 1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; xor_mask = '0; stuck0 = '0;
    t_in_valid = 1'b0; t_in_data = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_strobe", {31'd0, jk_strobe}, 32'd0);
    chk("rst_jk", {24'd0, jk_j, jk_k}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      write_word(tbl[i].d, tbl[i].ej, tbl[i].ek, tbl[i].es, tbl[i].lat);
    end
    chk("bank_after_table", {28'd0, bank0}, 32'd0);

    // Back-to-back unchanged words: one accept and one done per cycle.
    for (int i = 0; i < 3; i++) begin
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      chk("b2b_strobe", {31'd0, jk_strobe}, 32'd0);
      in_valid = 1'b1;
      in_data  = 4'b0000;
      sbq.push_back('{is_err: 1'b0, at_cyc: cyc + 1});
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_strobe_end", {31'd0, jk_strobe}, 32'd0);
    drain();

    // Recovery: readback corrupted only at the first CHECK.
    in_valid = 1'b1;
    in_data  = 4'b1010;
    sbq.push_back('{is_err: 1'b0, at_cyc: cyc + 7});
    tick();
    in_valid = 1'b0;
    chk("rec_strobe1", {31'd0, jk_strobe}, 32'd1);
    chk("rec_j1", {28'd0, jk_j}, 32'b1010);
    tick();
    tick();
    xor_mask = 4'b0011;
    tick();
    xor_mask = 4'b0000;
    chk("rec_strobe2", {31'd0, jk_strobe}, 32'd1);
    chk("rec_j2", {28'd0, jk_j}, 32'b0010);
    chk("rec_k2", {28'd0, jk_k}, 32'b0001);
    drain();
    chk("rec_err_count", {24'd0, err_count}, 32'd0);

    // Stuck-at-0 readback on bit 0: three strobes then err.
    stuck0   = 4'b0001;
    in_valid = 1'b1;
    in_data  = 4'b1011;
    sbq.push_back('{is_err: 1'b1, at_cyc: cyc + 10});
    nstrobe  = 0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (jk_strobe) begin
        nstrobe++;
        chk("stuck_j", {28'd0, jk_j}, 32'b0001);
        chk("stuck_k", {28'd0, jk_k}, 32'b0000);
      end
      tick();
    end
    chk("stuck_nstrobe", nstrobe, 32'd3);
    chk("stuck_err_count", {24'd0, err_count}, 32'd1);
    chk("stuck_in_ready", {31'd0, in_ready}, 32'd1);
    drain();
    stuck0 = 4'b0000;

    // Reset during WAIT; rst also wins over a simultaneous in_valid.
    in_valid = 1'b1;
    in_data  = 4'b0101;
    tick();
    in_valid = 1'b0;
    chk("rw_strobe", {31'd0, jk_strobe}, 32'd1);
    chk("rw_jk", {24'd0, jk_j, jk_k}, {24'd0, 4'b0101, 4'b1010});
    tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b0110;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rw_strobe_after", {31'd0, jk_strobe}, 32'd0);
    chk("rw_jk_after", {24'd0, jk_j, jk_k}, 32'd0);
    chk("rw_pulses_after", {30'd0, done, err}, 32'd0);
    chk("rw_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rw_err_count", {24'd0, err_count}, 32'd0);
    repeat (5) tick();
    chk("rw_no_strobe", {31'd0, jk_strobe}, 32'd0);
    write_word(4'b1111, 4'b1111, 4'b0000, 1'b1, 4);

    // Toggle mode: 0000 -> 1010 -> 0110, second write accepted in done cycle.
    t_in_valid = 1'b1;
    t_in_data  = 4'b1010;
    tick();
    t_in_valid = 1'b0;
    chk("tog_strobe1", {31'd0, t_strobe}, 32'd1);
    chk("tog_jk1", {24'd0, t_j, t_k}, {24'd0, 4'b1010, 4'b1010});
    tick();
    tick();
    chk("tog_done_early", {31'd0, t_done}, 32'd0);
    tick();
    chk("tog_done1", {31'd0, t_done}, 32'd1);
    chk("tog_ready1", {31'd0, t_in_ready}, 32'd1);
    t_in_valid = 1'b1;
    t_in_data  = 4'b0110;
    tick();
    t_in_valid = 1'b0;
    chk("tog_strobe2", {31'd0, t_strobe}, 32'd1);
    chk("tog_jk2", {24'd0, t_j, t_k}, {24'd0, 4'b1100, 4'b1100});
    tick();
    tick();
    tick();
    chk("tog_done2", {31'd0, t_done}, 32'd1);
    chk("tog_bank", {28'd0, t_qfb}, 32'b0110);
    chk("tog_err", {23'd0, t_err, t_errc}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
